// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids,
// default parameter values and the lock-counter step helper.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DEF_LOCK_MAX     = 8;
  localparam int DEF_READ_LATENCY = 1;

  // LOCK_MAX tops out at 255, so eight bits always suffice
  typedef logic [7:0] lock_cnt_t;

  // Advance the consecutive-grant count, saturating at the cap
  function automatic lock_cnt_t lock_cnt_next(input lock_cnt_t cnt, input lock_cnt_t cap);
    return (cnt >= cap) ? cap : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, port id} of each granted access
// DEPTH cycles so the returning memory data can be steered to its issuer.
// Synchronous clear drops every in-flight tag.
module dmem_rd_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic push_valid,
  input  logic push_id,
  output logic pop_valid,
  output logic pop_id
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] id_q;

  // Shift one stage per clock; stage 0 takes the tag of this cycle's grant
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q[0] <= push_valid;
      id_q[0]    <= push_id;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign pop_valid = valid_q[DEPTH-1];
  assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous data
// memory, with bounded lock bursts and tagged read return.
// Optional statistics counters are compiled in with DMEM_ARB_STATS_EN.
//
// state | meaning
// ARB   | no owner; grant by request, pointer breaks ties
// OWN0  | port 0 holds a lock burst; only port 0 may be granted
// OWN1  | port 1 holds a lock burst; only port 1 may be granted
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int LOCK_MAX     = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic              m0_wren,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_wren,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       m0_grant_cnt,
  output logic [31:0]       m1_grant_cnt,
  output logic [31:0]       conflict_cnt
`endif
);

  localparam lock_cnt_t LOCK_CNT = 8'(LOCK_MAX);

  arb_state_t  state_q;
  logic        ptr_q;
  lock_cnt_t   cnt_q;
  lock_cnt_t   cnt_inc;

  logic              gnt0;
  logic              gnt1;
  logic              gnt_any;
  logic              gnt_id;
  logic              other_req;
  logic              sel_lock;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] last_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              tag_valid;
  logic              tag_id;

  // Same-cycle grant decision; nothing is granted while reset is held
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (m0_req && m1_req) begin
            gnt0 = (ptr_q == PORT_CPU);
            gnt1 = (ptr_q != PORT_CPU);
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign other_req = gnt1 ? m0_req : m1_req;
  assign sel_lock  = gnt1 ? m1_lock  : m0_lock;
  assign sel_wren  = gnt1 ? m1_wren  : m0_wren;
  assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
  assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;
  assign cnt_inc   = lock_cnt_next(cnt_q, LOCK_CNT);

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  // Ownership FSM, round-robin pointer and lock-burst counter.
  // The cap is checked on the count that includes the current grant so a
  // burst never exceeds LOCK_MAX grants while the other port is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= PORT_CPU;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ARB: begin
          cnt_q <= '0;
          if (m0_req && m1_req) ptr_q <= ~ptr_q;
          if (gnt_any && sel_lock && !(LOCK_CNT == 8'd1 && other_req)) begin
            state_q <= gnt1 ? OWN1 : OWN0;
            cnt_q   <= 8'd1;
          end
        end
        OWN0, OWN1: begin
          if (!gnt_any) begin
            state_q <= ARB;
            cnt_q   <= '0;
          end else if (cnt_inc == LOCK_CNT && other_req) begin
            state_q <= ARB;
            cnt_q   <= '0;
            ptr_q   <= ~gnt_id;
          end else if (!sel_lock) begin
            state_q <= ARB;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= ARB;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Remember the last granted address/data so idle cycles hold the bus steady
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q  <= '0;
      last_wdata_q <= '0;
    end else if (gnt_any) begin
      last_addr_q  <= sel_addr;
      last_wdata_q <= sel_wdata;
    end
  end

  assign mem_wren  = gnt_any & sel_wren;
  assign mem_addr  = rst ? '0 : (gnt_any ? sel_addr  : last_addr_q);
  assign mem_wdata = rst ? '0 : (gnt_any ? sel_wdata : last_wdata_q);

  dmem_rd_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .push_valid (gnt_any & ~sel_wren),
    .push_id    (gnt_id),
    .pop_valid  (tag_valid),
    .pop_id     (tag_id)
  );

  assign m0_rvalid = !rst && tag_valid && (tag_id == PORT_CPU);
  assign m1_rvalid = !rst && tag_valid && (tag_id == PORT_AUX);

  // Capture return data on each port's pulse; the pulse cycle itself
  // forwards mem_rdata so data and rvalid appear together
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0_rvalid) rdata0_q <= mem_rdata;
      if (m1_rvalid) rdata1_q <= mem_rdata;
    end
  end

  assign m0_rdata = rst ? '0 : (m0_rvalid ? mem_rdata : rdata0_q);
  assign m1_rdata = rst ? '0 : (m1_rvalid ? mem_rdata : rdata1_q);

`ifdef DMEM_ARB_STATS_EN
  // Free-running grant and contention counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0) m0_grant_cnt <= m0_grant_cnt + 32'd1;
      if (gnt1) m1_grant_cnt <= m1_grant_cnt + 32'd1;
      if (m0_req && m1_req) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model (owner/streak/preference, a shadow
// memory and a pending-read record).
module tb_dmem_arbiter;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int LOCK_MAX = 8;

  logic              clk;
  logic              rst;
  logic              m0_req, m0_lock, m0_wren;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt, m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req, m1_lock, m1_wren;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] m0_grant_cnt, m1_grant_cnt, conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (RD_LAT),
    .LOCK_MAX     (LOCK_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_wren   (m0_wren),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_wren   (m1_wren),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .m0_grant_cnt (m0_grant_cnt),
    .m1_grant_cnt (m1_grant_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first single-port memory, one cycle read latency
  logic [DATA_W-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (mem_wren) tb_mem[mem_addr[7:0]] = mem_wdata;
    mem_rdata <= tb_mem[mem_addr[7:0]];
  end

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] sh_mem [256];
  int          own, streak, pref, pend_port, g;
  logic [31:0] pend_data, held0, held1, last_addr, last_wdata;
  int          model_grants, model_conf;
  logic        e_gnt0, e_gnt1, e_wren, e_rv0, e_rv1;
  logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;

  task automatic model_eval();
    g = -1;
    if (!rst) begin
      if (own == 0)       g = m0_req ? 0 : -1;
      else if (own == 1)  g = m1_req ? 1 : -1;
      else if (m0_req && m1_req) g = pref;
      else if (m0_req)    g = 0;
      else if (m1_req)    g = 1;
    end
    e_gnt0 = (g == 0);
    e_gnt1 = (g == 1);
    if (rst) begin
      e_wren = 0; e_addr = 0; e_wdata = 0;
      e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0;
    end else begin
      e_wren = 0; e_addr = last_addr; e_wdata = last_wdata;
      if (g == 0) begin e_wren = m0_wren; e_addr = m0_addr; e_wdata = m0_wdata; end
      if (g == 1) begin e_wren = m1_wren; e_addr = m1_addr; e_wdata = m1_wdata; end
      e_rv0 = (pend_port == 0);
      e_rv1 = (pend_port == 1);
      e_rd0 = e_rv0 ? pend_data : held0;
      e_rd1 = e_rv1 ? pend_data : held1;
    end
  endtask

  task automatic model_commit();
    int          other;
    logic        oreq, lk, wr;
    logic [31:0] a, d;
    if (rst) begin
      own = -1; streak = 0; pref = 0; pend_port = -1; pend_data = 0;
      held0 = 0; held1 = 0; last_addr = 0; last_wdata = 0;
      model_grants = 0; model_conf = 0;
      return;
    end
    if (m0_req && m1_req) model_conf++;
    if (pend_port == 0) held0 = pend_data;
    if (pend_port == 1) held1 = pend_data;
    pend_port = -1;
    if (g < 0) begin
      own = -1;
      return;
    end
    model_grants++;
    other = 1 - g;
    oreq  = (other == 0) ? m0_req : m1_req;
    lk    = (g == 0) ? m0_lock  : m1_lock;
    wr    = (g == 0) ? m0_wren  : m1_wren;
    a     = (g == 0) ? m0_addr  : m1_addr;
    d     = (g == 0) ? m0_wdata : m1_wdata;
    last_addr = a; last_wdata = d;
    if (wr) sh_mem[a[7:0]] = d;
    else begin pend_port = g; pend_data = sh_mem[a[7:0]]; end
    if (own < 0) begin
      if (m0_req && m1_req) pref = other;
      if (lk) begin
        own = g; streak = 1;
        if (LOCK_MAX <= 1 && oreq) begin own = -1; pref = other; end
      end
    end else begin
      streak = (streak < LOCK_MAX) ? streak + 1 : LOCK_MAX;
      if (streak >= LOCK_MAX && oreq) begin own = -1; pref = other; end
      else if (!lk) own = -1;
    end
  endtask

  // sample(): wait for the mid-cycle point and compute expectations
  // advance(): retire the cycle into the model and move to the next one
  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_lock = 0; m0_wren = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_wren = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1;
    m0_req = 1; m0_wren = 1; m0_addr = 32'h77; m0_wdata = 32'h1234;
    m1_req = 1; m1_addr = 32'h78;
    for (int i = 0; i < 2; i++) begin
      sample();
      total++;
      if ({m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid} !== 5'b0) begin
        bad++;
        $display("FAIL reset_ctrl cyc=%0d got=%b exp=00000", i, {m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid});
      end
      total++;
      if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'b0) begin
        bad++;
        $display("FAIL reset_data cyc=%0d addr=%h wdata=%h rd0=%h rd1=%h exp=0", i, mem_addr, mem_wdata, m0_rdata, m1_rdata);
      end
      advance();
    end
    rst = 0;
    idle_inputs();
    sample();
    total++;
    if ({m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid} !== 5'b0 || mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_idle ctrl=%b addr=%h exp=0", {m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid}, mem_addr);
    end
    advance();
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_wren = 0; m0_addr = 32'h10;
    sample();
    total++;
    if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 32'h10 || mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL single_gnt g0=%b g1=%b addr=%h wren=%b exp=1/0/10/0", m0_gnt, m1_gnt, mem_addr, mem_wren);
    end
    advance();
    idle_inputs();
    sample();
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL single_rvalid rv0=%b rd0=%h rv1=%b exp=1/deadbeef/0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    advance();
    sample();
    total++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_hold rv0=%b rd0=%h exp=0/deadbeef", m0_rvalid, m0_rdata);
    end
    advance();
  endtask

  task automatic test_alternating();
    int          n0, n1;
    logic [31:0] prev_addr;
    int          prev_port;
    n0 = 0; n1 = 0; prev_port = -1; prev_addr = 0;
    for (int i = 0; i < 5; i++) begin
      m0_req = (i < 4); m0_wren = 0; m0_addr = 32'h30 + 32'(n0);
      m1_req = (i < 4); m1_wren = 0; m1_addr = 32'h40 + 32'(n1);
      sample();
      if (i < 4) begin
        total++;
        if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          bad++;
          $display("FAIL alt_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end
      end
      if (prev_port >= 0) begin
        total++;
        if ({m0_rvalid, m1_rvalid} !== ((prev_port == 0) ? 2'b10 : 2'b01) ||
            ((prev_port == 0) ? m0_rdata : m1_rdata) !== init_word(int'(prev_addr))) begin
          bad++;
          $display("FAIL alt_rvalid cyc=%0d rv=%b rd0=%h rd1=%h exp_port=%0d exp_data=%h",
                   i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata, prev_port, init_word(int'(prev_addr)));
        end
      end
      prev_port = -1;
      if (i < 4) begin
        prev_port = i % 2;
        prev_addr = (i % 2 == 0) ? m0_addr : m1_addr;
        if (i % 2 == 0) n0++; else n1++;
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    // port 1 starts alone so it takes ownership; port 0 then waits throughout
    for (int i = 0; i < 12; i++) begin
      m1_req = 1; m1_lock = 1; m1_wren = 0; m1_addr = 32'h60;
      m0_req = (i > 0); m0_lock = 0; m0_wren = 0; m0_addr = 32'h50;
      sample();
      exp_g = (i == 8) ? 2'b10 : 2'b01;
      total++;
      if ({m0_gnt, m1_gnt} !== exp_g) begin
        bad++;
        $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, exp_g);
      end
      advance();
    end
    idle_inputs();
    sample();
    advance();
  endtask

  task automatic test_write_then_read();
    m0_req = 1; m0_wren = 1; m0_addr = 32'h20; m0_wdata = 32'h5A;
    sample();
    total++;
    if (m0_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h5A) begin
      bad++;
      $display("FAIL wr_cycle g0=%b wren=%b addr=%h wdata=%h exp=1/1/20/5a", m0_gnt, mem_wren, mem_addr, mem_wdata);
    end
    advance();
    idle_inputs();
    m1_req = 1; m1_wren = 0; m1_addr = 32'h20;
    sample();
    total++;
    if (m1_gnt !== 1'b1 || mem_wren !== 1'b0 || m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rd_cycle g1=%b wren=%b rv0=%b exp=1/0/0", m1_gnt, mem_wren, m0_rvalid);
    end
    advance();
    idle_inputs();
    sample();
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h5A || mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL wr_rd_data rv1=%b rd1=%h wren=%b exp=1/5a/0", m1_rvalid, m1_rdata, mem_wren);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    m0_req = 1; m0_lock = 1; m0_wren = 0; m0_addr = 32'h10;
    sample();
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_gnt got=%b exp=1", m0_gnt);
    end
    advance();
    idle_inputs();
    rst = 1;
    sample();
    total++;
    if ({m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid} !== 5'b0 ||
        {mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'b0) begin
      bad++;
      $display("FAIL rstmid_outputs ctrl=%b addr=%h rd0=%h rd1=%h exp=0",
               {m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid}, mem_addr, m0_rdata, m1_rdata);
    end
    advance();
    rst = 0;
    m1_req = 1; m1_wren = 0; m1_addr = 32'h11;
    sample();
    total++;
    if (m1_gnt !== 1'b1 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_unlock g1=%b rv0=%b rv1=%b exp=1/0/0", m1_gnt, m0_rvalid, m1_rvalid);
    end
    advance();
    idle_inputs();
    sample();
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== init_word(32'h11) || m0_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_after rv1=%b rd1=%h rv0=%b exp=1/%h/0", m1_rvalid, m1_rdata, m0_rvalid, init_word(32'h11));
    end
    advance();
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats();
    rst = 1;
    sample();
    advance();
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      m0_req = 1; m0_wren = 0; m0_addr = 32'h3;
      m1_req = (i < 6); m1_wren = 0; m1_addr = 32'h4;
      sample();
      advance();
    end
    idle_inputs();
    sample();
    total++;
    if (conflict_cnt !== 32'd6 || m0_grant_cnt !== 32'd7 || m1_grant_cnt !== 32'd3) begin
      bad++;
      $display("FAIL stats conf=%0d g0=%0d g1=%0d exp=6/7/3", conflict_cnt, m0_grant_cnt, m1_grant_cnt);
    end
    total++;
    if (m0_grant_cnt + m1_grant_cnt !== 32'(model_grants)) begin
      bad++;
      $display("FAIL stats_sum got=%0d exp=%0d", m0_grant_cnt + m1_grant_cnt, model_grants);
    end
    advance();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!m0_req || e_gnt0) begin
        m0_req   = ($urandom_range(0, 9) < 7);
        m0_wren  = ($urandom_range(0, 2) == 0);
        m0_lock  = ($urandom_range(0, 3) == 0);
        m0_addr  = 32'($urandom_range(0, 15));
        m0_wdata = $urandom;
      end
      if (!m1_req || e_gnt1) begin
        m1_req   = ($urandom_range(0, 9) < 7);
        m1_wren  = ($urandom_range(0, 2) == 0);
        m1_lock  = ($urandom_range(0, 2) == 0);
        m1_addr  = 32'($urandom_range(0, 15));
        m1_wdata = $urandom;
      end
      sample();
      total++;
      if ({m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid} !== {e_gnt0, e_gnt1, e_wren, e_rv0, e_rv1}) begin
        bad++;
        $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c,
                 {m0_gnt, m1_gnt, mem_wren, m0_rvalid, m1_rvalid}, {e_gnt0, e_gnt1, e_wren, e_rv0, e_rv1});
      end
      total++;
      if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        bad++;
        $display("FAIL rnd_membus cyc=%0d addr=%h wdata=%h exp=%h/%h", c, mem_addr, mem_wdata, e_addr, e_wdata);
      end
      total++;
      if (m0_rdata !== e_rd0) begin
        bad++;
        $display("FAIL rnd_rdata0 cyc=%0d got=%h exp=%h", c, m0_rdata, e_rd0);
      end
      total++;
      if (m1_rdata !== e_rd1) begin
        bad++;
        $display("FAIL rnd_rdata1 cyc=%0d got=%h exp=%h", c, m1_rdata, e_rd1);
      end
      total++;
      if (m0_gnt === 1'b1 && m1_gnt === 1'b1) begin
        bad++;
        $display("FAIL rnd_double_gnt cyc=%0d got=11 exp=at most one", c);
      end
      advance();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = init_word(i);
      sh_mem[i] = init_word(i);
    end
    tb_mem[16] = 32'hDEADBEEF;
    sh_mem[16] = 32'hDEADBEEF;
    own = -1; streak = 0; pref = 0; pend_port = -1; pend_data = 0;
    held0 = 0; held1 = 0; last_addr = 0; last_wdata = 0;
    model_grants = 0; model_conf = 0;
    e_gnt0 = 0; e_gnt1 = 0;
    rst = 1;
    idle_inputs();

    test_reset();
    test_single_read();
    test_alternating();
    test_lock();
    test_write_then_read();
    test_reset_mid();
`ifdef DMEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters on a cycle-by-cycle basis.
- Port 0 is the CPU load/store path (ALU result address, Rt write data). Port 1 is a secondary master, e.g. a debug loader or display scanner.
- Arbitration is round-robin. A requester may lock the memory for a bounded burst.
- Read data returns READ_LATENCY cycles after grant, tagged to the requester that issued it.

Parameters:
- ADDR_W, 32, address width passed through to the memory
- DATA_W, 32, data width
- READ_LATENCY, 1, cycles from the grant edge to valid mem_rdata; range 1..4
- LOCK_MAX, 8, maximum consecutive grants one port may hold under lock; range 1..255

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- m0_req  in  1  port 0 access request
- m0_lock  in  1  port 0 asks to keep ownership after this access
- m0_wren  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 access accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_W  port 0 read data
- m1_req, m1_lock, m1_wren, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory data
- mem_wren  out  1  to memory write enable
- mem_rdata  in  DATA_W  from memory q

Behaviour:
- Reset values: all gnt, rvalid and mem_wren are 0; mem_addr and mem_wdata are 0; rdata outputs are 0.
- Reset state: FSM = ARB, priority pointer = port 0, lock counter = 0, read-tag pipeline cleared.
- Grant timing:
  - gnt is combinational in the request cycle.
  - The memory samples mem_* at the next clk edge.
  - At most one gnt per cycle.
- Memory outputs:
  - mem_* carry the granted port's signals.
  - mem_wren = gnt & granted port's wren.
  - With no grant: mem_wren = 0 and mem_addr/mem_wdata hold their last value.
- FSM states: ARB, OWN0, OWN1.
  - ARB, single request: that port is granted.
  - ARB, both requesting: the port named by the pointer is granted, and the pointer flips to the other port.
  - ARB, after a grant with the granted port's lock=1: go to OWNx with counter = 1. Otherwise stay in ARB.
  - OWNx, port x requesting: port x is granted regardless of the other port, and the counter increments.
  - OWNx exit: return to ARB when x drops req or lock.
  - OWNx at counter == LOCK_MAX with the other port requesting: the next cycle is forced to ARB, and the pointer must name the other port.
  - OWNx at LOCK_MAX with the other port idle: ownership continues and the counter saturates.
  - OWNx with x req = 0: no grant this cycle. Go to ARB, and the next cycle arbitrates normally.
- Read return:
  - Each granted read pushes {valid, port id} into a READ_LATENCY-deep shift pipeline.
  - mx_rvalid pulses for 1 cycle exactly READ_LATENCY cycles after the grant edge.
  - mx_rdata is registered from mem_rdata on that pulse and held until the port's next rvalid.
  - Writes push valid = 0 and produce no rvalid.
- Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- Write-then-read to the same address on consecutive grants: the read returns the new data, because the memory is write-first.
- Reset mid-operation: in-flight reads are discarded, no rvalid is emitted after rst, and the lock is released.
- The requester holds req and all request fields until it sees gnt. The arbiter does not buffer requests.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- When defined, add outputs m0_grant_cnt and m1_grant_cnt (32 bits each), plus conflict_cnt (32 bits).
  - grant counters increment per grant.
  - conflict_cnt increments on each cycle both req are high.
  - All counters wrap at 2^32 and clear on rst.
- Without it, these ports and counters do not exist and the arbitration behaviour is identical.

Decomposition:
- Shared package:
  - FSM state encoding: ARB=2'd0, OWN0=2'd1, OWN1=2'd2
  - port id constants: PORT_CPU=1'b0, PORT_AUX=1'b1
  - default LOCK_MAX and READ_LATENCY constants
- One sub-module: dmem_rd_tag_pipe, the parameterised READ_LATENCY shift register of {valid, id}, with synchronous clear.

Test Plan:
- Reset, then m0 read of addr 0x10 holding 0xDEADBEEF → m0_gnt=1 the same cycle; m0_rvalid=1 and m0_rdata=0xDEADBEEF one cycle later; m1_rvalid stays 0.
- Both request reads every cycle for 4 cycles → grants go m0, m1, m0, m1; rvalid alternates with matching data; no cycle has two gnt.
- m1 with lock=1 and req for 12 cycles, m0 requesting throughout, LOCK_MAX=8 → m1 granted 8 consecutive cycles, then m0 granted on cycle 9.
- m0 writes 0x5A to addr 0x20, then m1 reads addr 0x20 on the next cycle → m1_rdata=0x5A; mem_wren=1 only in the write cycle.
- m0 read granted, rst asserted the following cycle → no rvalid on either port, all outputs at reset values, FSM in ARB.
- With DMEM_ARB_STATS_EN, run 10 cycles with 6 cycles of both requesting → conflict_cnt=6; m0_grant_cnt + m1_grant_cnt = total grants.
